// File: rtl/conv_sa_row_seq_pkg.sv
// Shared types and constants for the systolic-array row sequencer.
// Imported by the row sequencer top and its flush-spacing helper.
package conv_sa_row_seq_pkg;

   localparam int LEN_W_DEF = 16;
   localparam int P         = 4;   // PEs per row; default flush spacing
   localparam int W_W       = 8;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2
   } state_e;

   typedef struct packed {
      logic [W_W-1:0] w1;
      logic [W_W-1:0] w2;
      logic           rst;
      logic           flush;
      logic           x_en;
   } row_out_t;

   // Zero weights and all flags low: leaves every accumulator untouched.
   localparam row_out_t ROW_BUBBLE = '0;

endpackage

// File: rtl/conv_sa_row_seq_gap.sv
// Saturating cycles-since-last-flush counter and the flush-permit compare
// that keeps consecutive flushes at least FLUSH_GAP cycles apart.
module conv_sa_row_seq_gap #(
   parameter int FLUSH_GAP = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic start,
   input  logic flush_fire,
   input  logic is_last,
   output logic permit,
   output logic drained
);

   localparam int              SF_W = $clog2(FLUSH_GAP + 1);
   localparam logic [SF_W-1:0] GAP  = SF_W'(FLUSH_GAP);

   logic [SF_W-1:0] since_flush;

   // NOTE: sequential state uses non-blocking assignments only, so every
   // flop samples pre-edge values regardless of block ordering.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         since_flush <= '0;
      end else if (start) begin
         since_flush <= GAP;
      end else if (flush_fire) begin
         since_flush <= SF_W'(1);
      end else if (since_flush < GAP) begin
         since_flush <= since_flush + SF_W'(1);
      end
   end

   assign drained = (since_flush >= GAP);
   assign permit  = !is_last || drained;

endmodule

// File: rtl/conv_sa_row_seq.sv
// Row sequencer: accepts a job descriptor, streams weight pairs into the row
// head with rst/flush framing, and inserts bubbles on stalls or flush spacing.
module conv_sa_row_seq
   import conv_sa_row_seq_pkg::*;
#(
   parameter int LEN_W     = LEN_W_DEF,
   parameter int FLUSH_GAP = P
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             cfg_valid,
   output logic             cfg_ready,
   input  logic [LEN_W-1:0] cfg_vec_len,
   input  logic [LEN_W-1:0] cfg_n_vec,
   input  logic             w_valid,
   output logic             w_ready,
   input  logic [7:0]       w_data1,
   input  logic [7:0]       w_data2,
   output logic [7:0]       row_w1,
   output logic [7:0]       row_w2,
   output logic             row_rst,
   output logic             row_flush,
   output logic             row_x_en,
   output logic             busy,
   output logic             done,
   output logic             dbg_vec_begin,
   output logic             dbg_vec_end,
   output logic             dbg_vec_rst
);

   state_e           state_q, state_d;
   logic [LEN_W-1:0] k_m1_q, k_m1_d;
   logic [LEN_W-1:0] n_m1_q, n_m1_d;
   logic [LEN_W-1:0] elem_q, elem_d;
   logic [LEN_W-1:0] vec_q, vec_d;
   row_out_t         row_q, row_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             cfg_ready_q, cfg_ready_d;
   logic             bub_q, bub_d;
   logic             cfg_hs, w_hs, is_last, permit, drained;
   logic             job_start, flush_fire;

   assign cfg_hs  = cfg_valid & cfg_ready_q;
   assign is_last = (elem_q == k_m1_q);
   assign w_ready = (state_q == ST_RUN) & permit;
   assign w_hs    = w_valid & w_ready;

   conv_sa_row_seq_gap #(
      .FLUSH_GAP (FLUSH_GAP)
   ) u_gap (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (job_start),
      .flush_fire (flush_fire),
      .is_last    (is_last),
      .permit     (permit),
      .drained    (drained)
   );

   // NOTE: every variable gets its default first, so no path infers a latch.
   always_comb begin
      state_d    = state_q;
      k_m1_d     = k_m1_q;
      n_m1_d     = n_m1_q;
      elem_d     = elem_q;
      vec_d      = vec_q;
      row_d      = ROW_BUBBLE;
      done_d     = 1'b0;
      job_start  = 1'b0;
      flush_fire = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (cfg_hs) begin
               if (cfg_vec_len == '0 || cfg_n_vec == '0) begin
                  done_d = 1'b1;
               end else begin
                  k_m1_d    = cfg_vec_len - LEN_W'(1);
                  n_m1_d    = cfg_n_vec - LEN_W'(1);
                  elem_d    = '0;
                  vec_d     = '0;
                  job_start = 1'b1;
                  state_d   = ST_RUN;
               end
            end
         end
         ST_RUN: begin
            if (w_hs) begin
               row_d.w1    = w_data1;
               row_d.w2    = w_data2;
               row_d.rst   = (elem_q == '0);
               row_d.flush = is_last;
               row_d.x_en  = 1'b1;
               if (is_last) begin
                  flush_fire = 1'b1;
                  elem_d     = '0;
                  vec_d      = vec_q + LEN_W'(1);
                  if (vec_q == n_m1_q) begin
                     state_d = ST_DRAIN;
                  end
               end else begin
                  elem_d = elem_q + LEN_W'(1);
               end
            end
         end
         ST_DRAIN: begin
            // Psum chain has had FLUSH_GAP cycles to clear the final vector.
            if (drained) begin
               done_d  = 1'b1;
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      busy_d      = (state_d != ST_IDLE);
      bub_d       = busy_d && !w_hs;
      cfg_ready_d = (state_d == ST_IDLE) && !done_d;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         k_m1_q      <= '0;
         n_m1_q      <= '0;
         elem_q      <= '0;
         vec_q       <= '0;
         row_q       <= ROW_BUBBLE;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         cfg_ready_q <= 1'b0;
         bub_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         k_m1_q      <= k_m1_d;
         n_m1_q      <= n_m1_d;
         elem_q      <= elem_d;
         vec_q       <= vec_d;
         row_q       <= row_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         cfg_ready_q <= cfg_ready_d;
         bub_q       <= bub_d;
      end
   end

   assign cfg_ready     = cfg_ready_q;
   assign row_w1        = row_q.w1;
   assign row_w2        = row_q.w2;
   assign row_rst       = row_q.rst;
   assign row_flush     = row_q.flush;
   assign row_x_en      = row_q.x_en;
   assign busy          = busy_q;
   assign done          = done_q;
   assign dbg_vec_begin = row_q.rst;
   assign dbg_vec_end   = row_q.flush;
   assign dbg_vec_rst   = bub_q;

endmodule

// File: tb/tb_conv_sa_row_seq.sv
// Scoreboard bench for conv_sa_row_seq: expected row outputs are queued when
// weights are driven and compared one cycle later.
module tb_conv_sa_row_seq;

   localparam int GAP = 4;
   localparam int LW  = 16;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          cfg_valid = 1'b0;
   logic          cfg_ready;
   logic [LW-1:0] cfg_vec_len = '0;
   logic [LW-1:0] cfg_n_vec = '0;
   logic          w_valid = 1'b0;
   logic          w_ready;
   logic [7:0]    w_data1 = '0;
   logic [7:0]    w_data2 = '0;
   logic [7:0]    row_w1, row_w2;
   logic          row_rst, row_flush, row_x_en;
   logic          busy, done;
   logic          dbg_vec_begin, dbg_vec_end, dbg_vec_rst;

   typedef struct {
      logic [18:0] row;
      logic        dbg;
   } exp_t;

   exp_t exp_q[$];
   int   total = 0;
   int   bad = 0;

   conv_sa_row_seq #(
      .LEN_W     (LW),
      .FLUSH_GAP (GAP)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .cfg_valid     (cfg_valid),
      .cfg_ready     (cfg_ready),
      .cfg_vec_len   (cfg_vec_len),
      .cfg_n_vec     (cfg_n_vec),
      .w_valid       (w_valid),
      .w_ready       (w_ready),
      .w_data1       (w_data1),
      .w_data2       (w_data2),
      .row_w1        (row_w1),
      .row_w2        (row_w2),
      .row_rst       (row_rst),
      .row_flush     (row_flush),
      .row_x_en      (row_x_en),
      .busy          (busy),
      .done          (done),
      .dbg_vec_begin (dbg_vec_begin),
      .dbg_vec_end   (dbg_vec_end),
      .dbg_vec_rst   (dbg_vec_rst)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] all_outs();
      return 32'({cfg_ready, w_ready, row_w1, row_w2, row_rst, row_flush, row_x_en,
                  busy, done, dbg_vec_begin, dbg_vec_end, dbg_vec_rst});
   endfunction

   task automatic wait_cfg_ready();
      bit ok = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (cfg_ready) begin
            ok = 1'b1;
            break;
         end
         step();
      end
      check("cfg_ready_wait", 32'(ok), 32'd1);
   endtask

   // One job: per cycle, pop/compare the expected row output, check the
   // handshake signals, then drive the next weight and push its expectation.
   task automatic run_job(input int k, input int n, input int stall_at, input int stall_len,
                          input bit hold, input int abort_after);
      int         elem, vec, sf, sent, done_cyc, stall_left;
      bit         ok, rdy, wv, hs;
      logic [7:0] d1, d2;
      exp_t       e;

      wait_cfg_ready();
      cfg_valid   = 1'b1;
      cfg_vec_len = LW'(k);
      cfg_n_vec   = LW'(n);
      step();
      cfg_valid = hold;

      elem = 0; vec = 0; sf = GAP; sent = 0; done_cyc = -1; stall_left = stall_len;
      ok = 1'b0;
      exp_q.delete();
      exp_q.push_back('{row: 19'd0, dbg: 1'b1});

      for (int c = 0; c < 400; c++) begin
         e = exp_q.pop_front();
         check("row", 32'({row_w1, row_w2, row_rst, row_flush, row_x_en}), 32'(e.row));
         check("dbg_begin_end", 32'({dbg_vec_begin, dbg_vec_end}), 32'(e.row[2:1]));
         check("dbg_vec_rst", 32'(dbg_vec_rst), 32'(e.dbg));
         check("done", 32'(done), 32'(c == done_cyc));
         check("busy", 32'(busy), 32'(done_cyc < 0 || c < done_cyc));
         check("cfg_ready", 32'(cfg_ready), 32'(done_cyc >= 0 && c == done_cyc + 1));
         if (done_cyc >= 0 && c == done_cyc + 1) begin
            ok = 1'b1;
            break;
         end

         rdy = (vec < n) && !(elem == k - 1 && sf < GAP);
         check("w_ready", 32'(w_ready), 32'(rdy));

         wv = (sent >= k * n) || !(sent == stall_at && stall_left > 0);
         d1 = (sent < k * n) ? 8'(sent * 37 + 11) : 8'hEE;
         d2 = (sent < k * n) ? (8'(sent * 13 + 200) ^ 8'h5A) : 8'hEE;
         hs = wv && rdy;

         if (hs) begin
            exp_q.push_back('{row: {d1, d2, elem == 0, elem == k - 1, 1'b1}, dbg: 1'b0});
            sent++;
            if (elem == k - 1) begin
               elem = 0;
               vec++;
               sf = 1;
               if (vec == n) done_cyc = c + 1 + GAP;
            end else begin
               elem++;
               if (sf < GAP) sf++;
            end
         end else begin
            exp_q.push_back('{row: 19'd0, dbg: (done_cyc < 0 || c + 1 < done_cyc)});
            if (sf < GAP) sf++;
            if (!wv) stall_left--;
         end

         w_valid = wv;
         w_data1 = d1;
         w_data2 = d2;
         step();
         if (abort_after >= 0 && sent == abort_after) begin
            ok = 1'b1;
            break;
         end
      end
      check("job_end", 32'(ok), 32'd1);
      w_valid = 1'b0;
   endtask

   task automatic zero_job(input int len, input int n);
      wait_cfg_ready();
      cfg_valid   = 1'b1;
      cfg_vec_len = LW'(len);
      cfg_n_vec   = LW'(n);
      w_valid     = 1'b1;
      w_data1     = 8'h77;
      w_data2     = 8'h66;
      step();
      cfg_valid = 1'b0;
      check("zero_done", 32'(done), 32'd1);
      check("zero_busy", 32'(busy), 32'd0);
      check("zero_cfg_ready_in_done", 32'(cfg_ready), 32'd0);
      for (int i = 0; i < 4; i++) begin
         check("zero_row_quiet", 32'({row_w1, row_w2, row_rst, row_flush, row_x_en, busy}), 32'd0);
         check("zero_w_ready", 32'(w_ready), 32'd0);
         step();
         check("zero_done_once", 32'(done), 32'd0);
         check("zero_cfg_ready_after", 32'(cfg_ready), 32'd1);
      end
      w_valid = 1'b0;
   endtask

   initial begin
      step();
      check("reset_outputs", all_outs(), 32'd0);
      step();
      check("reset_outputs_hold", all_outs(), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      step();

      // Two vectors of four: contiguous stream, flush spacing already met.
      run_job(4, 2, -1, 0, 1'b0, -1);
      // Single-element vectors: rst and flush together, spaced by the gap.
      run_job(1, 3, -1, 0, 1'b0, -1);
      // Upstream stall after element 2: three zero-weight bubbles.
      run_job(5, 1, 2, 3, 1'b0, -1);
      // Degenerate descriptors: done only, no row activity.
      zero_job(0, 5);
      zero_job(3, 0);

      // Reset mid-job aborts without done.
      run_job(6, 1, -1, 0, 1'b0, 2);
      #2;
      rst_n = 1'b0;
      #1;
      check("abort_async_outputs", all_outs(), 32'd0);
      step();
      check("abort_outputs_held", all_outs(), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         step();
         check("abort_no_done", 32'({done, busy, row_x_en}), 32'd0);
      end
      run_job(2, 1, -1, 0, 1'b0, -1);

      // Descriptor held high: second accepted only the cycle after done.
      run_job(3, 2, -1, 0, 1'b1, -1);
      run_job(3, 2, -1, 0, 1'b0, -1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
